// File: rtl/coherence_bus_if.sv
// coherence_bus_if: cache-side request/snoop signals and the shared RAM port of the coherence bus.
interface coherence_bus_if;
    logic [1:0]        dren;
    logic [1:0]        dwen;
    logic [1:0][31:0]  daddr;
    logic [1:0][31:0]  dstore;
    logic [1:0]        cctrans;
    logic [1:0]        ccwrite;
    logic [1:0]        dwait;
    logic [1:0][31:0]  dload;
    logic [1:0]        ccwait;
    logic [1:0]        ccinv;
    logic [1:0][31:0]  ccsnoopaddr;
    logic              ram_ren;
    logic              ram_wen;
    logic [31:0]       ram_addr;
    logic [31:0]       ram_store;
    logic [31:0]       ram_load;
    logic [1:0]        ram_state;

    modport master (
        output dren, dwen, daddr, dstore, cctrans, ccwrite, ram_load, ram_state,
        input  dwait, dload, ccwait, ccinv, ccsnoopaddr, ram_ren, ram_wen, ram_addr, ram_store
    );
    modport slave (
        input  dren, dwen, daddr, dstore, cctrans, ccwrite, ram_load, ram_state,
        output dwait, dload, ccwait, ccinv, ccsnoopaddr, ram_ren, ram_wen, ram_addr, ram_store
    );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: dual-core snooping controller serialising cache accesses onto one RAM port.
module coherence_bus_ctrl (
    input logic clk,
    input logic rst,
    coherence_bus_if.slave bus
);
    localparam logic [1:0] ACCESS = 2'd2;
    typedef enum logic [2:0] {IDLE, SNOOP, SWB0, SWB1, RD, WR, INV} state_t;
    state_t state, state_n;
    logic req, req_n, rr, rr_n, inv_wb, inv_wb_n, o, win, acc;
    logic [1:0] pinv, pinv_set, pinv_clr, request;
    logic [1:0][31:0] pinvaddr;
    logic [31:0] snoop_addr;

    assign o = ~req;
    assign acc = bus.ram_state == ACCESS;
    assign request = bus.dren | bus.dwen | pinv;
    assign win = &request ? rr : request[1];
    assign bus.dload = {bus.ram_load, bus.ram_load};
    // a cctrans while being snooped is an acknowledge, not an invalidate
    assign pinv_set = bus.cctrans & ~bus.dren & ~bus.dwen & ~bus.ccwait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            req <= 1'b0;
            rr <= 1'b0;
            inv_wb <= 1'b0;
            pinv <= '0;
            pinvaddr <= '0;
            snoop_addr <= '0;
        end else begin
            state <= state_n;
            req <= req_n;
            rr <= rr_n;
            inv_wb <= inv_wb_n;
            pinv <= (pinv & ~pinv_clr) | pinv_set;
            for (int c = 0; c < 2; c++)
                if (pinv_set[c]) pinvaddr[c] <= bus.daddr[c];
            if (state == IDLE && |request) snoop_addr <= {bus.daddr[win][31:3], 3'b000};
        end
    end

    always_comb begin
        state_n = state;
        req_n = req;
        rr_n = rr;
        inv_wb_n = inv_wb;
        pinv_clr = '0;
        bus.dwait = 2'b11;
        bus.ccwait = '0;
        bus.ccinv = '0;
        bus.ccsnoopaddr = '0;
        bus.ram_ren = 1'b0;
        bus.ram_wen = 1'b0;
        bus.ram_addr = '0;
        bus.ram_store = '0;
        case (state)
            IDLE: if (|request) begin
                req_n = win;
                rr_n = ~win;
                inv_wb_n = 1'b0;
                state_n = pinv[win] ? INV : bus.dwen[win] ? WR : bus.cctrans[win] ? SNOOP : RD;
            end
            SNOOP: begin
                bus.ccwait[o] = 1'b1;
                bus.ccsnoopaddr[o] = snoop_addr;
                if (bus.cctrans[o]) state_n = bus.ccwrite[o] ? SWB0 : RD;
            end
            SWB0, SWB1: begin
                bus.ram_wen = bus.dwen[o];
                bus.ram_addr = bus.daddr[o];
                bus.ram_store = bus.dstore[o];
                if (!bus.dren[o] && !bus.dwen[o]) state_n = IDLE;
                else if (acc && bus.dwen[o]) begin
                    bus.dwait[o] = 1'b0;
                    state_n = state == SWB0 ? SWB1 : inv_wb ? IDLE : RD;
                end
            end
            RD: begin
                bus.ram_ren = 1'b1;
                bus.ram_addr = bus.daddr[req];
                if (!bus.dren[req] && !bus.dwen[req]) state_n = IDLE;
                else if (acc) begin
                    bus.dwait[req] = 1'b0;
                    state_n = bus.daddr[req][2] ? IDLE : RD;
                end
            end
            WR: begin
                bus.ram_wen = 1'b1;
                bus.ram_addr = bus.daddr[req];
                bus.ram_store = bus.dstore[req];
                if (!bus.dren[req] && !bus.dwen[req]) state_n = IDLE;
                else if (acc) begin
                    bus.dwait[req] = 1'b0;
                    state_n = IDLE;
                end
            end
            INV: begin
                bus.ccwait[o] = 1'b1;
                bus.ccinv[o] = 1'b1;
                bus.ccsnoopaddr[o] = pinvaddr[req];
                if (bus.cctrans[o]) begin
                    pinv_clr[req] = 1'b1;
                    inv_wb_n = 1'b1;
                    state_n = bus.ccwrite[o] ? SWB0 : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed cycle-by-cycle vectors for the coherence bus controller.
module tb_coherence_bus_ctrl;
    localparam logic [1:0] BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int pass = 0;
    int total = 0;
    logic [31:0] mem [0:255];

    coherence_bus_if bus();
    coherence_bus_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // tiny RAM: writes land on ACCESS edges, reads are combinational
    always @(posedge clk) if (bus.ram_wen && bus.ram_state == ACCESS) mem[bus.ram_addr[9:2]] <= bus.ram_store;
    assign bus.ram_load = mem[bus.ram_addr[9:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic clear_inputs();
        bus.dren = '0;
        bus.dwen = '0;
        bus.daddr = '0;
        bus.dstore = '0;
        bus.cctrans = '0;
        bus.ccwrite = '0;
        bus.ram_state = ACCESS;
    endtask

    initial begin
        clear_inputs();
        @(negedge clk); #1;
        check("rst_dwait", 32'(bus.dwait), 32'h3);
        check("rst_ccwait", 32'(bus.ccwait), 32'h0);
        check("rst_ccinv", 32'(bus.ccinv), 32'h0);
        check("rst_snoopaddr", bus.ccsnoopaddr[1], 32'h0);
        check("rst_ramstrobes", {30'h0, bus.ram_ren, bus.ram_wen}, 32'h0);
        check("rst_ramaddr", bus.ram_addr, 32'h0);
        rst = 1'b0;

        // clean fill: IDLE, SNOOP, RD, RD
        @(negedge clk);
        bus.dren[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h40; #1;
        check("cf_idle_dwait", 32'(bus.dwait), 32'h3);
        @(negedge clk);
        bus.cctrans[0] = 1'b0; bus.cctrans[1] = 1'b1; #1;
        check("cf_ccwait", 32'(bus.ccwait), 32'h2);
        check("cf_snoopaddr", bus.ccsnoopaddr[1], 32'h40);
        check("cf_ccinv", 32'(bus.ccinv), 32'h0);
        @(negedge clk);
        bus.cctrans[1] = 1'b0; #1;
        check("cf_rd0_ccwait", 32'(bus.ccwait), 32'h0);
        check("cf_rd0_ren", 32'(bus.ram_ren), 32'h1);
        check("cf_rd0_addr", bus.ram_addr, 32'h40);
        check("cf_rd0_dwait", 32'(bus.dwait), 32'h2);
        @(negedge clk);
        bus.daddr[0] = 32'h44; #1;
        check("cf_rd1_addr", bus.ram_addr, 32'h44);
        check("cf_rd1_dwait", 32'(bus.dwait), 32'h2);
        @(negedge clk);
        bus.dren[0] = 1'b0; #1;
        check("cf_done_dwait", 32'(bus.dwait), 32'h3);
        check("cf_done_ren", 32'(bus.ram_ren), 32'h0);

        // dirty fill: core1 writes back both words before core0 reads them
        @(negedge clk);
        bus.dren[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h40; #1;
        @(negedge clk);
        bus.cctrans[0] = 1'b0; bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1;
        bus.dwen[1] = 1'b1; bus.daddr[1] = 32'h40; bus.dstore[1] = 32'hAAAA_0001; #1;
        check("df_ccwait", 32'(bus.ccwait), 32'h2);
        @(negedge clk);
        bus.cctrans[1] = 1'b0; bus.ccwrite[1] = 1'b0; #1;
        check("df_swb0_wen", 32'(bus.ram_wen), 32'h1);
        check("df_swb0_addr", bus.ram_addr, 32'h40);
        check("df_swb0_store", bus.ram_store, 32'hAAAA_0001);
        check("df_swb0_dwait", 32'(bus.dwait), 32'h1);
        @(negedge clk);
        bus.daddr[1] = 32'h44; bus.dstore[1] = 32'hAAAA_0002; #1;
        check("df_swb1_addr", bus.ram_addr, 32'h44);
        check("df_swb1_store", bus.ram_store, 32'hAAAA_0002);
        check("df_swb1_dwait", 32'(bus.dwait), 32'h1);
        @(negedge clk);
        bus.dwen[1] = 1'b0; #1;
        check("df_rd0_addr", bus.ram_addr, 32'h40);
        check("df_rd0_load", bus.dload[0], 32'hAAAA_0001);
        check("df_rd0_dwait", 32'(bus.dwait), 32'h2);
        @(negedge clk);
        bus.daddr[0] = 32'h44; #1;
        check("df_rd1_load", bus.dload[0], 32'hAAAA_0002);
        check("df_rd1_dwait", 32'(bus.dwait), 32'h2);
        @(negedge clk);
        bus.dren[0] = 1'b0; #1;
        check("df_done_dwait", 32'(bus.dwait), 32'h3);

        // invalidate pulse from core1 during core0's fill is held and served afterwards
        @(negedge clk);
        bus.dren[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h40; #1;
        @(negedge clk);
        bus.cctrans[0] = 1'b0; bus.cctrans[1] = 1'b1; #1;
        @(negedge clk);
        bus.daddr[1] = 32'h80; #1;
        check("inv_rd0_dwait", 32'(bus.dwait), 32'h2);
        @(negedge clk);
        bus.cctrans[1] = 1'b0; bus.daddr[1] = 32'h0; bus.daddr[0] = 32'h44; #1;
        check("inv_rd1_dwait", 32'(bus.dwait), 32'h2);
        @(negedge clk);
        bus.dren[0] = 1'b0; #1;
        check("inv_idle_ccwait", 32'(bus.ccwait), 32'h0);
        @(negedge clk);
        bus.cctrans[0] = 1'b1; #1;
        check("inv_ccwait", 32'(bus.ccwait), 32'h1);
        check("inv_ccinv", 32'(bus.ccinv), 32'h1);
        check("inv_snoopaddr", bus.ccsnoopaddr[0], 32'h80);
        @(negedge clk);
        bus.cctrans[0] = 1'b0; #1;
        check("inv_ack_ccwait", 32'(bus.ccwait), 32'h0);
        check("inv_ack_ccinv", 32'(bus.ccinv), 32'h0);
        @(negedge clk); #1;
        check("inv_cleared", 32'(bus.ccwait), 32'h0);

        // write stalled by BUSY and ERROR, completing on ACCESS
        @(negedge clk);
        bus.dwen[0] = 1'b1; bus.daddr[0] = 32'h200; bus.dstore[0] = 32'h1234_5678; #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.ram_state = i < 3 ? BUSY : ERROR; #1;
            check($sformatf("wr_stall%0d_dwait", i), 32'(bus.dwait), 32'h3);
            check($sformatf("wr_stall%0d_wen", i), 32'(bus.ram_wen), 32'h1);
        end
        @(negedge clk);
        bus.ram_state = ACCESS; #1;
        check("wr_done_dwait", 32'(bus.dwait), 32'h2);
        check("wr_done_addr", bus.ram_addr, 32'h200);
        @(negedge clk);
        bus.dwen[0] = 1'b0; #1;
        check("wr_idle_dwait", 32'(bus.dwait), 32'h3);

        // reset asserted in SWB0 aborts the transaction
        @(negedge clk);
        bus.dren[0] = 1'b1; bus.cctrans[0] = 1'b1; bus.daddr[0] = 32'h40; #1;
        @(negedge clk);
        bus.cctrans[0] = 1'b0; bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1;
        bus.dwen[1] = 1'b1; bus.daddr[1] = 32'h40; bus.dstore[1] = 32'h55; #1;
        @(negedge clk);
        bus.cctrans[1] = 1'b0; bus.ccwrite[1] = 1'b0; #1;
        check("rs_swb0_wen", 32'(bus.ram_wen), 32'h1);
        rst = 1'b1; #1;
        check("rs_now_dwait", 32'(bus.dwait), 32'h3);
        check("rs_now_wen", 32'(bus.ram_wen), 32'h0);
        @(negedge clk); #1;
        check("rs_next_dwait", 32'(bus.dwait), 32'h3);
        check("rs_next_ccwait", 32'(bus.ccwait), 32'h0);
        check("rs_next_wen", 32'(bus.ram_wen), 32'h0);
        clear_inputs();
        rst = 1'b0;

        // simultaneous writes after reset: core0 first, then core1, rr back to 0
        @(negedge clk);
        bus.dwen = 2'b11; bus.daddr[0] = 32'h100; bus.daddr[1] = 32'h104;
        bus.dstore[0] = 32'hD0; bus.dstore[1] = 32'hD1; #1;
        check("arb_idle_dwait", 32'(bus.dwait), 32'h3);
        @(negedge clk); #1;
        check("arb_c0_addr", bus.ram_addr, 32'h100);
        check("arb_c0_store", bus.ram_store, 32'hD0);
        check("arb_c0_dwait", 32'(bus.dwait), 32'h2);
        @(negedge clk);
        bus.dwen[0] = 1'b0; #1;
        check("arb_gap_wen", 32'(bus.ram_wen), 32'h0);
        @(negedge clk); #1;
        check("arb_c1_addr", bus.ram_addr, 32'h104);
        check("arb_c1_dwait", 32'(bus.dwait), 32'h1);
        @(negedge clk);
        bus.dwen[1] = 1'b0; #1;
        @(negedge clk);
        bus.dwen = 2'b11; #1;
        @(negedge clk); #1;
        check("arb_rr_end", bus.ram_addr, 32'h100);
        @(negedge clk);
        bus.dwen = 2'b00; #1;

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
